// File: rtl/fetch_cycle_seq.sv
// rtl/fetch_cycle_seq.sv - 8-phase instruction-fetch bus-cycle sequencer (A1 A2 A3 M1 M2 X1 X2 X3)
// Optional two-word instruction tracking enabled by FETCH_TWO_WORD_EN.
module fetch_cycle_seq #(
    parameter int SYNC_PHASE = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] pc_nibble,
    input  logic [3:0] bus_in,
`ifdef FETCH_TWO_WORD_EN
    input  logic       two_word,
    output logic       word_idx,
`endif
    output logic [1:0] pc_sel,
    output logic       pc_inc,
    output logic [3:0] bus_out,
    output logic       bus_oe,
    output logic       sync,
    output logic [2:0] phase,
    output logic [3:0] opr,
    output logic [3:0] opa,
    output logic       instr_valid
);

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_t;

    localparam logic [2:0] SYNC_IDX = SYNC_PHASE[2:0];

    phase_t     r_phase;
    phase_t     w_phase_nxt;
    logic [3:0] r_opr;
    logic [3:0] r_opa;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= PH_X3;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // Only X3 can stall; every other phase runs to completion regardless of run.
    always_comb begin
        w_phase_nxt = r_phase;
        case (r_phase)
            PH_X3:   w_phase_nxt = run ? PH_A1 : PH_X3;
            default: w_phase_nxt = phase_t'(r_phase + 3'd1);
        endcase
    end

    always_comb begin
        pc_sel      = 2'b00;
        bus_oe      = 1'b0;
        bus_out     = 4'h0;
        pc_inc      = 1'b0;
        instr_valid = 1'b0;
        case (r_phase)
            PH_A1: begin
                pc_sel  = 2'b00;
                bus_oe  = 1'b1;
                bus_out = pc_nibble;
            end
            PH_A2: begin
                pc_sel  = 2'b01;
                bus_oe  = 1'b1;
                bus_out = pc_nibble;
            end
            PH_A3: begin
                pc_sel  = 2'b10;
                bus_oe  = 1'b1;
                bus_out = pc_nibble;
            end
            PH_X1: begin
                pc_inc      = 1'b1;
                instr_valid = 1'b1;
            end
            default: begin
                pc_sel = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_opr <= 4'h0;
            r_opa <= 4'h0;
        end else begin
            if (r_phase == PH_M1) begin
                r_opr <= bus_in;
            end
            if (r_phase == PH_M2) begin
                r_opa <= bus_in;
            end
        end
    end

`ifdef FETCH_TWO_WORD_EN
    logic r_word_idx;

    // two_word is only meaningful on a first word; a second word always returns to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word_idx <= 1'b0;
        end else if (r_phase == PH_X1) begin
            if (r_word_idx) begin
                r_word_idx <= 1'b0;
            end else if (two_word) begin
                r_word_idx <= 1'b1;
            end
        end
    end

    assign word_idx = r_word_idx;
`endif

    assign phase = r_phase;
    assign opr   = r_opr;
    assign opa   = r_opa;
    assign sync  = (r_phase == SYNC_IDX);

endmodule

// File: tb/tb_fetch_cycle_seq.sv
// tb/tb_fetch_cycle_seq.sv - directed self-checking bench for fetch_cycle_seq
module tb_fetch_cycle_seq;

    logic       clk;
    logic       reset;
    logic       run;
    logic [3:0] pc_nibble;
    logic [3:0] bus_in;
    logic [1:0] pc_sel;
    logic       pc_inc;
    logic [3:0] bus_out;
    logic       bus_oe;
    logic       sync;
    logic [2:0] phase;
    logic [3:0] opr;
    logic [3:0] opa;
    logic       instr_valid;
`ifdef FETCH_TWO_WORD_EN
    logic       two_word;
    logic       word_idx;
`endif

    int n_tests;
    int n_fail;
    int cyc;

    logic [11:0] pc;

    fetch_cycle_seq #(.SYNC_PHASE(7)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .pc_nibble   (pc_nibble),
        .bus_in      (bus_in),
`ifdef FETCH_TWO_WORD_EN
        .two_word    (two_word),
        .word_idx    (word_idx),
`endif
        .pc_sel      (pc_sel),
        .pc_inc      (pc_inc),
        .bus_out     (bus_out),
        .bus_oe      (bus_oe),
        .sync        (sync),
        .phase       (phase),
        .opr         (opr),
        .opa         (opa),
        .instr_valid (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC stack stand-in: nibble mux on pc_sel, increment on pc_inc
    always_comb begin
        case (pc_sel)
            2'b00:   pc_nibble = pc[3:0];
            2'b01:   pc_nibble = pc[7:4];
            2'b10:   pc_nibble = pc[11:8];
            default: pc_nibble = 4'hF;
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pc_inc) pc <= pc + 12'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run   = 1'b0;
        tick();
        tick();
        n_tests++;
        if (phase !== 3'd7) begin n_fail++; $display("FAIL reset_phase got %0d want 7", phase); end
        n_tests++;
        if (opr !== 4'h0 || opa !== 4'h0) begin n_fail++; $display("FAIL reset_opcode got %h/%h want 0/0", opr, opa); end
        n_tests++;
        if ({pc_sel, bus_oe, bus_out, pc_inc, instr_valid, sync} !== {2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_decode got sel=%b oe=%b out=%h inc=%b iv=%b sync=%b want 00 0 0 0 0 1",
                     pc_sel, bus_oe, bus_out, pc_inc, instr_valid, sync);
        end
    endtask

    task automatic test_fetch();
        logic [3:0] exp_nib [3];
        logic [1:0] exp_sel [3];
        exp_nib[0] = 4'h3; exp_nib[1] = 4'h2; exp_nib[2] = 4'h1;
        exp_sel[0] = 2'b00; exp_sel[1] = 2'b01; exp_sel[2] = 2'b10;
        pc    = 12'h123;
        run   = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (phase !== 3'(i) || pc_sel !== exp_sel[i] || bus_oe !== 1'b1 || bus_out !== exp_nib[i] || pc_inc !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_addr%0d got ph=%0d sel=%b oe=%b out=%h inc=%b want ph=%0d sel=%b oe=1 out=%h inc=0",
                         i, phase, pc_sel, bus_oe, bus_out, pc_inc, i, exp_sel[i], exp_nib[i]);
            end
        end
        tick();
        bus_in = 4'hD;
        n_tests++;
        if (phase !== 3'd3 || bus_oe !== 1'b0 || bus_out !== 4'h0) begin
            n_fail++; $display("FAIL fetch_m1 got ph=%0d oe=%b out=%h want 3 0 0", phase, bus_oe, bus_out);
        end
        tick();
        bus_in = 4'h5;
        n_tests++;
        if (opr !== 4'hD) begin n_fail++; $display("FAIL fetch_opr got %h want d", opr); end
        tick();
        bus_in = 4'h0;
        n_tests++;
        if (phase !== 3'd5 || pc_inc !== 1'b1 || instr_valid !== 1'b1 || opr !== 4'hD || opa !== 4'h5) begin
            n_fail++;
            $display("FAIL fetch_x1 got ph=%0d inc=%b iv=%b opr=%h opa=%h want 5 1 1 d 5",
                     phase, pc_inc, instr_valid, opr, opa);
        end
        tick();
        n_tests++;
        if (pc_inc !== 1'b0 || instr_valid !== 1'b0 || sync !== 1'b0) begin
            n_fail++; $display("FAIL fetch_x2 got inc=%b iv=%b sync=%b want 0 0 0", pc_inc, instr_valid, sync);
        end
        tick();
        n_tests++;
        if (phase !== 3'd7 || sync !== 1'b1) begin n_fail++; $display("FAIL fetch_x3 got ph=%0d sync=%b want 7 1", phase, sync); end
        tick();
        n_tests++;
        if (phase !== 3'd0 || bus_out !== 4'h4 || opr !== 4'hD || opa !== 4'h5) begin
            n_fail++;
            $display("FAIL fetch_next_a1 got ph=%0d out=%h opr=%h opa=%h want 0 4 d 5", phase, bus_out, opr, opa);
        end
        tick();
        n_tests++;
        if (phase !== 3'd1 || bus_out !== 4'h2 || opr !== 4'hD || opa !== 4'h5) begin
            n_fail++;
            $display("FAIL fetch_next_a2 got ph=%0d out=%h opr=%h opa=%h want 1 2 d 5", phase, bus_out, opr, opa);
        end
    endtask

    task automatic test_run_drop();
        int incs;
        int budget;
        incs   = 0;
        budget = 0;
        run    = 1'b0;
        while (phase !== 3'd7 && budget < 12) begin
            tick();
            budget++;
            if (pc_inc === 1'b1) incs++;
        end
        n_tests++;
        if (phase !== 3'd7 || budget !== 6) begin
            n_fail++; $display("FAIL run_drop_reach_x3 got ph=%0d after %0d clocks want 7 after 6", phase, budget);
        end
        n_tests++;
        if (incs !== 1) begin n_fail++; $display("FAIL run_drop_pc_inc got %0d pulses want 1", incs); end
    endtask

    task automatic test_stall();
        int bad;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (phase !== 3'd7 || sync !== 1'b1 || pc_inc !== 1'b0 || bus_oe !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL stall_hold got %0d bad clocks want 0", bad); end
        run = 1'b1;
        tick();
        n_tests++;
        if (phase !== 3'd0 || sync !== 1'b0) begin n_fail++; $display("FAIL stall_release got ph=%0d sync=%b want 0 0", phase, sync); end
    endtask

    task automatic test_reset_mid();
        int incs;
        incs = 0;
        bus_in = 4'hA;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pc_inc === 1'b1) incs++;
        end
        n_tests++;
        if (phase !== 3'd4 || opr !== 4'hA) begin n_fail++; $display("FAIL mid_pre got ph=%0d opr=%h want 4 a", phase, opr); end
        reset = 1'b1;
        tick();
        if (pc_inc === 1'b1) incs++;
        n_tests++;
        if (phase !== 3'd7 || opr !== 4'h0 || opa !== 4'h0) begin
            n_fail++; $display("FAIL mid_reset got ph=%0d opr=%h opa=%h want 7 0 0", phase, opr, opa);
        end
        tick();
        if (pc_inc === 1'b1) incs++;
        reset = 1'b0;
        run   = 1'b0;
        tick();
        if (pc_inc === 1'b1) incs++;
        n_tests++;
        if (incs !== 0 || phase !== 3'd7) begin
            n_fail++; $display("FAIL mid_no_inc got %0d pulses ph=%0d want 0 7", incs, phase);
        end
        bus_in = 4'h0;
    endtask

    task automatic test_back_to_back();
        int first;
        int last;
        int incs;
        int gap_bad;
        first   = -1;
        last    = -1;
        incs    = 0;
        gap_bad = 0;
        run     = 1'b1;
        for (int i = 0; i < 26; i++) begin
            tick();
            if (pc_inc === 1'b1) begin
                if (last >= 0 && (i - last) != 8) gap_bad++;
                if (first < 0) first = i;
                last = i;
                incs++;
            end
        end
        n_tests++;
        if (incs !== 3 || gap_bad !== 0 || first !== 5) begin
            n_fail++;
            $display("FAIL b2b_period got pulses=%0d badgaps=%0d first=%0d want 3 0 5", incs, gap_bad, first);
        end
        run = 1'b0;
        for (int i = 0; i < 8 && phase !== 3'd7; i++) tick();
    endtask

`ifdef FETCH_TWO_WORD_EN
    task automatic test_two_word();
        logic exp_wi [16];
        int bad;
        bad = 0;
        // phases seen after each tick: A1..X3 twice; word_idx flips after each X1
        for (int i = 0; i < 16; i++) exp_wi[i] = (i >= 6 && i <= 13) ? 1'b1 : 1'b0;
        two_word = 1'b1;
        run      = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (word_idx !== exp_wi[i]) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL two_word_seq got %0d bad clocks want 0", bad); end
        two_word = 1'b0;
        run      = 1'b0;
    endtask
`endif

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        pc        = 12'h000;
        reset     = 1'b1;
        run       = 1'b0;
        bus_in    = 4'h0;
`ifdef FETCH_TWO_WORD_EN
        two_word  = 1'b0;
`endif
        test_reset();
        test_fetch();
        test_run_drop();
        test_stall();
        test_reset_mid();
        test_back_to_back();
`ifdef FETCH_TWO_WORD_EN
        test_two_word();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
